bridge_wbuf: RTL and testbench
==============================

BRIDGE_WBUF -- requirements
Module: bridge_wbuf

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width on both sides.
REQ-002 SHALL have parameter DATA_W, default 8, data width on both sides.
REQ-003 SHALL have parameter BASE_ADDR, default 16'h8000, upstream window base.
REQ-004 SHALL have parameter REMAP_BASE, default 16'h0000, downstream address of window offset 0.
REQ-005 SHALL have parameter WBUF_DEPTH, default 4 (power of 2, >=2), posted-write FIFO entries.
REQ-006 SHALL have parameter TIMEOUT, default 255, max downstream wait cycles.
REQ-007 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); reset is asynchronous, active-high.
REQ-008 SHALL have upstream inputs s_address_in (ADDR_W), s_address_in_valid (1), s_data_in (DATA_W), s_data_in_valid (1), s_rw (1; 1=read, 0=write), split_grant (1).
REQ-009 SHALL have upstream outputs s_ready, s_ack, s_split_ack, split_req, s_data_out_valid (all 1) and s_data_out (DATA_W).
REQ-010 SHALL have downstream outputs m_req, m_address_out_valid, m_data_out_valid, m_rw, m_ready (all 1), m_address_out (ADDR_W), m_data_out (DATA_W).
REQ-011 SHALL have downstream inputs m_grant, m_ack, m_split_ack, m_data_in_valid (all 1), m_data_in (DATA_W).
REQ-012 SHALL have status outputs wbuf_level ($clog2(WBUF_DEPTH)+1), timeout_err (1, sticky), err_count (8, saturating).

Function
REQ-013 SHALL accept an upstream request in any cycle where s_address_in_valid=1 and s_ready=1; writes also require s_data_in_valid=1 that cycle, else ignored.
REQ-014 SHALL translate address as m_address_out = s_address_in - BASE_ADDR + REMAP_BASE, modulo 2^ADDR_W.
REQ-015 SHALL push accepted writes into the FIFO and pulse s_ack one cycle later (posted write).
REQ-016 SHALL hold s_ready=0 when FIFO is full or a read is in flight; otherwise s_ready=1.
REQ-017 SHALL answer an accepted read with a one-cycle s_split_ack pulse the next cycle and hold the read until all FIFO entries queued before it have completed downstream.
REQ-018 SHALL run downstream FSM IDLE -> ARB -> ADDR -> WAIT -> IDLE; ARB holds m_req=1 until m_grant=1; ADDR drives m_address_out_valid=1, m_rw, and for writes m_data_out_valid=1 with m_data_out, for exactly one cycle.
REQ-019 SHALL leave WAIT on m_ack=1 (write, FIFO pops) or m_data_in_valid=1 (read, data latched); m_split_ack=1 only keeps the FSM in WAIT, m_req stays 0.
REQ-020 SHALL prioritise FIFO head over a pending read in IDLE; the read is issued only when wbuf_level=0.
REQ-021 SHALL count WAIT cycles and, on reaching TIMEOUT, set timeout_err=1, increment err_count (saturating at 255), pop a write or return all-ones data for a read, and return to IDLE.
REQ-022 SHALL, after read data latches, assert split_req until split_grant=1, then drive s_data_out with s_data_out_valid=1 for one cycle, then drop split_req and reopen s_ready.
REQ-023 SHALL keep m_ready=1 whenever state is WAIT, else 0.
REQ-024 SHALL update wbuf_level correctly when push and pop occur in the same cycle (level unchanged).
REQ-025 SHALL keep all outputs registered; no combinational path from upstream inputs to downstream outputs.

Reset
REQ-026 SHALL on rst=1 immediately clear FIFO, read pending, FSM to IDLE, timeout_err=0, err_count=0.
REQ-027 SHALL hold every 1-bit output at 0 except s_ready=1, and all bus outputs at 0, while in reset.
REQ-028 SHALL drop any in-flight transaction on reset mid-operation without a late s_ack, s_data_out_valid or split_req afterwards.

Verification
REQ-029 Single write 0x8004 data 0xA5, grant immediate, m_ack after 2 cycles -> s_ack next cycle after accept, m_address_out=0x0004, m_data_out=0xA5, wbuf_level back to 0.
REQ-030 Five back-to-back writes, grant withheld, depth 4 -> s_ready=0 after fourth, wbuf_level=4, fifth accepted only after first m_ack.
REQ-031 Two writes then read 0x8010, downstream returns 0x3C -> both writes appear downstream before read address 0x0010; s_split_ack, split_req, then s_data_out=0x3C after split_grant.
REQ-032 Read with m_split_ack then m_data_in_valid 6 cycles later (0x5A) -> no re-request, s_data_out=0x5A.
REQ-033 No downstream response, TIMEOUT=8 -> WAIT exits after 8 cycles, timeout_err=1, err_count=1, read returns 0xFF.
REQ-034 rst pulsed during WAIT with 3 FIFO entries -> wbuf_level=0, m_req=0, s_ready=1, no later s_ack.

Source files
------------

// File: rtl/bridge_wbuf.sv
// Address-window bridge with a posted-write FIFO and split-transaction reads.
// A read only goes downstream once every write queued before it has completed.
module bridge_wbuf #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h8000,
    parameter logic [ADDR_W-1:0] REMAP_BASE = 16'h0000,
    parameter int                WBUF_DEPTH = 4,
    parameter int                TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             s_address_in,
    input  logic                          s_address_in_valid,
    input  logic [DATA_W-1:0]             s_data_in,
    input  logic                          s_data_in_valid,
    input  logic                          s_rw,
    input  logic                          split_grant,
    output logic                          s_ready,
    output logic                          s_ack,
    output logic                          s_split_ack,
    output logic                          split_req,
    output logic                          s_data_out_valid,
    output logic [DATA_W-1:0]             s_data_out,
    output logic                          m_req,
    output logic                          m_address_out_valid,
    output logic                          m_data_out_valid,
    output logic                          m_rw,
    output logic                          m_ready,
    output logic [ADDR_W-1:0]             m_address_out,
    output logic [DATA_W-1:0]             m_data_out,
    input  logic                          m_grant,
    input  logic                          m_ack,
    input  logic                          m_split_ack,
    input  logic                          m_data_in_valid,
    input  logic [DATA_W-1:0]             m_data_in,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic                          timeout_err,
    output logic [7:0]                    err_count
);
    localparam int              PW         = $clog2(WBUF_DEPTH);
    localparam int              CW         = $clog2(TIMEOUT + 1);
    localparam logic [PW:0]     FULL_LEVEL = (PW + 1)'(WBUF_DEPTH);
    localparam logic [CW-1:0]   LAST_WAIT  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARB, ADDR, WAIT} state_t;
    state_t r_state, w_nextState;

    logic [ADDR_W-1:0] r_fifoAddr [WBUF_DEPTH];
    logic [DATA_W-1:0] r_fifoData [WBUF_DEPTH];
    logic [PW-1:0]     r_wrPtr, r_rdPtr;
    logic [PW:0]       r_level;

    logic              r_rdPending, r_rdIssued, r_splitReq, r_dOutValid;
    logic              r_sAck, r_sSplitAck, r_curIsRead, r_timeoutErr;
    logic [ADDR_W-1:0] r_rdAddr, r_curAddr;
    logic [DATA_W-1:0] r_rdData, r_curData, r_dOut;
    logic [CW-1:0]     r_waitCnt;
    logic [7:0]        r_errCount;

    logic              w_sReady, w_acceptWr, w_acceptRd, w_startWrite, w_startRead;
    logic              w_rsp, w_timeout, w_done, w_pop;
    logic [ADDR_W-1:0] w_xlatAddr;

    assign w_sReady     = (r_level != FULL_LEVEL) && !r_rdPending;
    assign w_acceptWr   = s_address_in_valid && w_sReady && !s_rw && s_data_in_valid;
    assign w_acceptRd   = s_address_in_valid && w_sReady && s_rw;
    assign w_xlatAddr   = s_address_in - BASE_ADDR + REMAP_BASE;
    assign w_startWrite = (r_state == IDLE) && (r_level != '0);
    assign w_startRead  = (r_state == IDLE) && (r_level == '0) && r_rdPending && !r_rdIssued;
    assign w_rsp        = r_curIsRead ? m_data_in_valid : m_ack;
    assign w_timeout    = (r_state == WAIT) && !w_rsp && !m_split_ack && (r_waitCnt == LAST_WAIT);
    assign w_done       = (r_state == WAIT) && (w_rsp || w_timeout);
    assign w_pop        = w_done && !r_curIsRead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_startWrite || w_startRead) w_nextState = ARB;
            ARB:     if (m_grant) w_nextState = ADDR;
            ADDR:    w_nextState = WAIT;
            WAIT:    if (w_done) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        m_req               = (r_state == ARB);
        m_address_out_valid = (r_state == ADDR);
        m_data_out_valid    = (r_state == ADDR) && !r_curIsRead;
        m_rw                = (r_state == ADDR) && r_curIsRead;
        m_address_out       = (r_state == ADDR) ? r_curAddr : '0;
        m_data_out          = ((r_state == ADDR) && !r_curIsRead) ? r_curData : '0;
        m_ready             = (r_state == WAIT);
    end

    always_ff @(posedge clk) begin
        if (w_acceptWr) begin
            r_fifoAddr[r_wrPtr] <= w_xlatAddr;
            r_fifoData[r_wrPtr] <= s_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_acceptWr) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)      r_rdPtr <= r_rdPtr + 1'b1;
            if (w_acceptWr && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_acceptWr) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_curIsRead <= 1'b0;
            r_curAddr   <= '0;
            r_curData   <= '0;
        end else if (w_startWrite) begin
            r_curIsRead <= 1'b0;
            r_curAddr   <= r_fifoAddr[r_rdPtr];
            r_curData   <= r_fifoData[r_rdPtr];
        end else if (w_startRead) begin
            r_curIsRead <= 1'b1;
            r_curAddr   <= r_rdAddr;
            r_curData   <= '0;
        end
    end

    // A split acknowledge means the slave promised a late answer, so the wait window restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
            r_errCount   <= '0;
        end else begin
            if (r_state != WAIT || m_split_ack) r_waitCnt <= '0;
            else if (!w_done)                   r_waitCnt <= r_waitCnt + 1'b1;
            if (w_timeout) begin
                r_timeoutErr <= 1'b1;
                if (r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPending <= 1'b0;
            r_rdIssued  <= 1'b0;
            r_splitReq  <= 1'b0;
            r_dOutValid <= 1'b0;
            r_rdAddr    <= '0;
            r_rdData    <= '0;
            r_dOut      <= '0;
            r_sAck      <= 1'b0;
            r_sSplitAck <= 1'b0;
        end else begin
            r_sAck      <= w_acceptWr;
            r_sSplitAck <= w_acceptRd;
            if (w_acceptRd) begin
                r_rdPending <= 1'b1;
                r_rdAddr    <= w_xlatAddr;
            end
            if (w_startRead) r_rdIssued <= 1'b1;
            if (w_done && r_curIsRead) begin
                r_rdData   <= w_rsp ? m_data_in : '1;
                r_splitReq <= 1'b1;
            end
            if (r_splitReq && split_grant && !r_dOutValid) begin
                r_dOutValid <= 1'b1;
                r_dOut      <= r_rdData;
            end
            if (r_dOutValid) begin
                r_dOutValid <= 1'b0;
                r_dOut      <= '0;
                r_splitReq  <= 1'b0;
                r_rdPending <= 1'b0;
                r_rdIssued  <= 1'b0;
            end
        end
    end

    assign s_ready          = w_sReady;
    assign s_ack            = r_sAck;
    assign s_split_ack      = r_sSplitAck;
    assign split_req        = r_splitReq;
    assign s_data_out_valid = r_dOutValid;
    assign s_data_out       = r_dOut;
    assign wbuf_level       = r_level;
    assign timeout_err      = r_timeoutErr;
    assign err_count        = r_errCount;
endmodule

// File: tb/tb_bridge_wbuf.sv
// Bench for bridge_wbuf: directed scenarios and a randomized mix, checked against
// a transaction-level model of the address window, write ordering and memory contents.
module tb_bridge_wbuf;
    localparam int          DEPTH = 4;
    localparam int          TOUT  = 8;
    localparam logic [15:0] BASE  = 16'h8000;
    localparam logic [15:0] REMAP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_address_in;
    logic        s_address_in_valid, s_data_in_valid, s_rw, split_grant;
    logic [7:0]  s_data_in;
    logic        s_ready, s_ack, s_split_ack, split_req, s_data_out_valid;
    logic [7:0]  s_data_out;
    logic        m_req, m_address_out_valid, m_data_out_valid, m_rw, m_ready;
    logic [15:0] m_address_out;
    logic [7:0]  m_data_out;
    logic        m_grant, m_ack, m_split_ack, m_data_in_valid;
    logic [7:0]  m_data_in;
    logic [2:0]  wbuf_level;
    logic        timeout_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    bridge_wbuf #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(BASE), .REMAP_BASE(REMAP),
                  .WBUF_DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .s_address_in(s_address_in), .s_address_in_valid(s_address_in_valid),
        .s_data_in(s_data_in), .s_data_in_valid(s_data_in_valid), .s_rw(s_rw),
        .split_grant(split_grant), .s_ready(s_ready), .s_ack(s_ack),
        .s_split_ack(s_split_ack), .split_req(split_req),
        .s_data_out_valid(s_data_out_valid), .s_data_out(s_data_out),
        .m_req(m_req), .m_address_out_valid(m_address_out_valid),
        .m_data_out_valid(m_data_out_valid), .m_rw(m_rw), .m_ready(m_ready),
        .m_address_out(m_address_out), .m_data_out(m_data_out),
        .m_grant(m_grant), .m_ack(m_ack), .m_split_ack(m_split_ack),
        .m_data_in_valid(m_data_in_valid), .m_data_in(m_data_in),
        .wbuf_level(wbuf_level), .timeout_err(timeout_err), .err_count(err_count)
    );

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t       expQ[$];
    txn_t       gotQ[$];
    logic [7:0] modelMem [65536];
    logic [7:0] respMem  [65536];

    int checks = 0;
    int errors = 0;

    bit grantOn = 1, ackRandom = 0, splitOn = 0, splitRandom = 0, silent = 0;
    int grantPct = 100, ackDelay = 0, splitDelay = 1;
    int slaveAcks = 0, sAckCount = 0, waitCycles = 0;

    bit          slvBusy = 0, slvIsRd = 0, slvSplit = 0;
    int          slvCnt = 0;
    logic [15:0] slvAddr;
    logic [7:0]  slvData;

    // Downstream slave: grants, records address phases, answers after a programmable delay.
    initial begin
        m_grant = 0; m_ack = 0; m_split_ack = 0; m_data_in_valid = 0; m_data_in = 0;
        forever begin
            @(posedge clk); #1;
            if (s_ack) sAckCount++;
            if (m_ready) waitCycles++;
            m_ack = 0; m_split_ack = 0; m_data_in_valid = 0; m_data_in = 0;
            m_grant = m_req && grantOn && ($urandom_range(1, 100) <= grantPct);
            if (m_address_out_valid) begin
                gotQ.push_back('{m_rw, m_address_out, m_data_out});
                slvBusy = 1; slvIsRd = m_rw; slvAddr = m_address_out; slvData = m_data_out;
                slvCnt   = ackRandom ? int'($urandom_range(0, 4)) : ackDelay;
                slvSplit = slvIsRd && (splitRandom ? ($urandom_range(0, 1) == 1) : splitOn);
                if (slvSplit) slvCnt = (splitRandom ? int'($urandom_range(1, 5)) : splitDelay) - 1;
            end else if (slvBusy && m_ready && !silent) begin
                if (slvSplit) begin
                    m_split_ack = 1;
                    slvSplit = 0;
                end else if (slvCnt > 0) begin
                    slvCnt--;
                end else begin
                    slvBusy = 0;
                    if (slvIsRd) begin
                        m_data_in_valid = 1;
                        m_data_in = respMem[slvAddr];
                    end else begin
                        m_ack = 1;
                        respMem[slvAddr] = slvData;
                        slaveAcks++;
                    end
                end
            end else if (!m_ready) begin
                slvBusy = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] xlat(input logic [15:0] a);
        return a - BASE + REMAP;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic [7:0] data);
        int budget = 300;
        while (!s_ready && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("ready_wait", s_ready, 1);
        s_address_in = addr; s_address_in_valid = 1; s_rw = rw;
        s_data_in = data; s_data_in_valid = !rw;
        tick();
        s_address_in_valid = 0; s_data_in_valid = 0; s_rw = 0;
        if (rw) begin
            expQ.push_back('{1'b1, xlat(addr), 8'h00});
        end else begin
            expQ.push_back('{1'b0, xlat(addr), data});
            modelMem[addr] = data;
        end
    endtask

    task automatic waitIdle(input string tag);
        int budget = 500;
        while ((wbuf_level != 0 || m_req || m_address_out_valid || m_ready) && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput({tag, "_drain"}, {wbuf_level, m_req, m_ready}, 0);
    endtask

    task automatic readReturn(input string tag, input logic [7:0] exp, input int hold);
        int budget = 300;
        while (!split_req && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput({tag, "_split_req"}, split_req, 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput({tag, "_hold"}, {split_req, s_data_out_valid}, 2'b10);
        end
        split_grant = 1;
        budget = 20;
        while (!s_data_out_valid && budget > 0) begin
            tick();
            budget--;
        end
        split_grant = 0;
        checkOutput({tag, "_dvalid"}, s_data_out_valid, 1);
        checkOutput({tag, "_rdata"}, s_data_out, exp);
        tick();
        checkOutput({tag, "_after"}, {s_data_out_valid, split_req, s_ready}, 3'b001);
    endtask

    task automatic checkLog(input string tag);
        txn_t e, g;
        checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expQ.pop_front();
            g = gotQ.pop_front();
            checkOutput({tag, "_rw"}, g.rw, e.rw);
            checkOutput({tag, "_addr"}, g.addr, e.addr);
            if (!e.rw) checkOutput({tag, "_wdata"}, g.data, e.data);
        end
        expQ.delete();
        gotQ.delete();
    endtask

    initial begin
        int sAck0, acks0;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;

        for (int i = 0; i < 65536; i++) begin
            modelMem[i] = 8'h00;
            respMem[i]  = 8'h00;
        end
        s_address_in = 0; s_address_in_valid = 0; s_data_in = 0;
        s_data_in_valid = 0; s_rw = 0; split_grant = 0;
        rst = 1;
        #3;
        checkOutput("reset_flags", {s_ack, s_split_ack, split_req, s_data_out_valid, m_req,
                    m_address_out_valid, m_data_out_valid, m_rw, m_ready, timeout_err}, 0);
        checkOutput("reset_ready", s_ready, 1);
        checkOutput("reset_buses", {m_address_out, m_data_out, s_data_out}, 0);
        checkOutput("reset_status", {wbuf_level, err_count}, 0);
        @(negedge clk);
        rst = 0;
        tick();

        // Single posted write
        ackDelay = 2;
        sAck0 = sAckCount;
        applyStimulus(0, 16'h8004, 8'hA5);
        checkOutput("w1_s_ack", s_ack, 1);
        checkOutput("w1_level", wbuf_level, 1);
        tick();
        checkOutput("w1_ack_pulse", s_ack, 0);
        waitIdle("w1");
        checkLog("w1");
        checkOutput("w1_level_end", wbuf_level, 0);
        checkOutput("w1_ack_count", sAckCount - sAck0, 1);

        // Fill the FIFO with grant withheld
        grantOn = 0;
        ackDelay = 1;
        sAck0 = sAckCount;
        for (int i = 0; i < 4; i++) applyStimulus(0, 16'h8040 + 16'(i), 8'(8'h10 + i));
        checkOutput("full_ready", s_ready, 0);
        checkOutput("full_level", wbuf_level, 4);
        checkOutput("full_req", m_req, 1);
        tick(3);
        checkOutput("full_hold", {s_ready, wbuf_level}, {1'b0, 3'd4});
        acks0 = slaveAcks;
        grantOn = 1;
        applyStimulus(0, 16'h8044, 8'h14);
        checkOutput("fifth_after_ack", slaveAcks > acks0, 1);
        waitIdle("full");
        checkLog("full");
        checkOutput("full_ack_count", sAckCount - sAck0, 5);

        // Read ordered behind two posted writes
        ackDelay = 0;
        respMem[xlat(16'h8010)] = 8'h3C;
        modelMem[16'h8010] = 8'h3C;
        applyStimulus(0, 16'h8020, 8'h11);
        applyStimulus(0, 16'h8021, 8'h22);
        applyStimulus(1, 16'h8010, 8'h00);
        checkOutput("rd_split_ack", s_split_ack, 1);
        checkOutput("rd_ready_low", s_ready, 0);
        readReturn("rd", 8'h3C, 3);
        checkLog("rd");

        // Read answered with a split acknowledge first
        splitOn = 1;
        splitDelay = 6;
        respMem[xlat(16'h8030)] = 8'h5A;
        modelMem[16'h8030] = 8'h5A;
        applyStimulus(1, 16'h8030, 8'h00);
        readReturn("split", 8'h5A, 0);
        checkLog("split");
        splitOn = 0;

        // Randomized mix across the window and below its base
        grantPct = 60;
        ackRandom = 1;
        splitRandom = 1;
        sAck0 = sAckCount;
        acks0 = 0;
        for (int i = 0; i < 40; i++) begin
            rw   = ($urandom_range(0, 3) == 0);
            addr = 16'h7F80 + 16'($urandom_range(0, 255));
            data = 8'($urandom);
            if (rw) begin
                applyStimulus(1, addr, 8'h00);
                checkOutput("rnd_split_ack", s_split_ack, 1);
                readReturn("rnd_rd", modelMem[addr], 0);
            end else begin
                applyStimulus(0, addr, data);
                checkOutput("rnd_s_ack", s_ack, 1);
                acks0++;
            end
        end
        waitIdle("rnd");
        checkLog("rnd");
        checkOutput("rnd_ack_count", sAckCount - sAck0, acks0);
        checkOutput("rnd_no_err", {timeout_err, err_count}, 0);
        grantPct = 100;
        ackRandom = 0;
        splitRandom = 0;

        // Silent slave: read then write time out
        silent = 1;
        waitCycles = 0;
        applyStimulus(1, 16'h9010, 8'h00);
        readReturn("to_rd", 8'hFF, 0);
        checkOutput("to_wait_len", waitCycles, TOUT);
        checkOutput("to_err", timeout_err, 1);
        checkOutput("to_count1", err_count, 1);
        applyStimulus(0, 16'h9000, 8'h77);
        waitIdle("to_wr");
        checkOutput("to_count2", err_count, 2);
        checkOutput("to_sticky", timeout_err, 1);
        checkLog("to");

        // Reset while a write sits in WAIT with three entries queued
        for (int i = 0; i < 3; i++) applyStimulus(0, 16'hA000 + 16'(i), 8'(8'hC0 + i));
        for (int i = 0; i < 20 && !m_ready; i++) tick();
        checkOutput("rst_in_wait", m_ready, 1);
        checkOutput("rst_level_before", wbuf_level, 3);
        #1 rst = 1;
        #1;
        checkOutput("rst_level", wbuf_level, 0);
        checkOutput("rst_flags", {m_req, m_ready, split_req, s_ready}, 4'b0001);
        checkOutput("rst_status", {timeout_err, err_count}, 0);
        tick(2);
        rst = 0;
        silent = 0;
        sAck0 = sAckCount;
        tick(20);
        checkOutput("rst_no_late_ack", sAckCount - sAck0, 0);
        checkOutput("rst_quiet", {split_req, s_data_out_valid, m_req, wbuf_level}, 0);
        expQ.delete();
        gotQ.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
